ram_sync_dp: RTL and testbench
==============================

// Module: ram_sync_dp
// PURPOSE
//   Parametrised simple dual-port synchronous RAM: one write port, one read port, single clock.
//   Registered read with a valid strobe and selectable read-during-write policy.
//   A hardware clear sequencer zeroes every word after reset or on request.
//   Sits as the general data/scratch memory; generalises the fixed 32x8 single-port ram.
// PARAMETERS
//   DATA_W       8   word width in bits
//   ADDR_W       5   address width; DEPTH = 2**ADDR_W words
//   WRITE_FIRST  1   same-address read during write: 1 = return new data, 0 = return old data
// PORTS
//   clock   in   1        rising-edge clock for all state
//   reset   in   1        asynchronous, active-high reset
//   clear   in   1        request full memory zeroing (one-cycle pulse or level)
//   we      in   1        write enable
//   waddr   in   ADDR_W   write address
//   wdata   in   DATA_W   write data
//   re      in   1        read enable
//   raddr   in   ADDR_W   read address
//   rdata   out  DATA_W   registered read data
//   rvalid  out  1        rdata updated this cycle (one-cycle pulse per accepted read)
//   busy    out  1        clear sequencer running; user ports ignored
// BEHAVIOUR
//   Reset (async assert, sync release): rdata=0, rvalid=0, busy=1, clr_cnt=0, FSM=INIT.
//     Memory array itself is not reset asynchronously; INIT zeroes it.
//   FSM states: INIT, RUN.
//     INIT: each cycle mem[clr_cnt]<=0, clr_cnt++; at clr_cnt==DEPTH-1 write then -> RUN.
//       INIT lasts exactly DEPTH cycles after reset release; busy=1 throughout.
//     RUN: busy=0. clear=1 sampled -> INIT with clr_cnt=0 (busy=1 from next cycle).
//   While busy=1: we, re ignored; no user write; rvalid=0; rdata holds its value.
//   clear asserted during INIT: ignored, sequence continues uninterrupted.
//   reset asserted mid-INIT: sequence restarts from 0 after release (full DEPTH cycles).
//   Write (RUN): edge with we=1 -> mem[waddr]<=wdata. No write latency beyond that edge.
//   Read (RUN): edge N with re=1 -> rdata=mem[raddr], rvalid=1 after edge N (1-cycle latency).
//     re=0: rvalid=0 next cycle, rdata holds last read value.
//   Same cycle we=1, re=1, waddr==raddr: rdata=wdata if WRITE_FIRST=1, else prior mem contents.
//   Different addresses same cycle: independent, both complete.
//   clear and we/re in the same RUN cycle: clear wins; that write and read are still
//     performed (they are sampled while busy=0), then zeroing overwrites all words.
//   Addresses are exactly ADDR_W bits: no out-of-range case; no wrap logic needed.
//   All ports full-width; no truncation or extension inside the block.
// TESTING (DATA_W=8, ADDR_W=5, 2-cycle clock period)
//   1 Release reset -> busy=1 for exactly 32 cycles then 0; read addr 0..31 -> rdata=0, rvalid each.
//   2 Write mem[j]=j+1, j=0..31; read j=0..31 back-to-back -> rdata=j+1 one cycle later, rvalid=1.
//   3 mem[5]=6; same cycle we=1 waddr=5 wdata=8'hAA, re=1 raddr=5 -> rdata=8'hAA (WRITE_FIRST=1),
//     8'h06 (WRITE_FIRST=0); subsequent read of 5 -> 8'hAA in both.
//   4 we=1 waddr=3 wdata=8'h55 and re=1 during INIT -> rvalid stays 0; after INIT read 3 -> 8'h00.
//   5 After test 2, pulse clear -> busy=1 for 32 cycles; clear re-pulsed mid-INIT changes nothing;
//     all reads then return 8'h00.
//   6 Assert reset at INIT cycle 10 -> rdata=0, rvalid=0 immediately; after release busy=1 for 32 cycles.

Source files
------------

// File: rtl/ram_sync_dp.sv
// -----------------------------------------------------------------------------
// ram_sync_dp
//   Simple dual-port synchronous RAM: one write port, one read port, one clock.
//   Reads are registered (one cycle of latency) and flagged by a valid strobe.
//   The read-during-write policy for a shared address is set by WRITE_FIRST.
//   A clear sequencer zeroes every word after reset and whenever clear is
//   sampled high while the memory is running.
//
// Parameters
//   DATA_W       word width in bits
//   ADDR_W       address width; the array holds 2**ADDR_W words
//   WRITE_FIRST  same-address read during write: 1 = new data, 0 = old data
//
// Ports
//   clock   in   1        rising-edge clock for all state
//   reset   in   1        asynchronous, active-high reset
//   clear   in   1        request full memory zeroing (pulse or level)
//   we      in   1        write enable
//   waddr   in   ADDR_W   write address
//   wdata   in   DATA_W   write data
//   re      in   1        read enable
//   raddr   in   ADDR_W   read address
//   rdata   out  DATA_W   registered read data
//   rvalid  out  1        rdata updated this cycle (one pulse per accepted read)
//   busy    out  1        clear sequencer running; user ports ignored
// -----------------------------------------------------------------------------
module ram_sync_dp #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int WRITE_FIRST = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              run;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic              rd_en_p0;
    logic              rdw_hit_p0;
    logic [DATA_W-1:0] rd_word_p0;

    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;

    assign run  = (state == ST_RUN);
    assign busy = ~run;

    // Sequencer: INIT walks clr_cnt across every word, then hands over to RUN.
    // clr_cnt wraps back to zero on the last INIT cycle, so RUN always holds 0
    // and a later clear restarts from the first word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (clear) begin
                        state   <= ST_INIT;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Single physical write port shared between the zeroing sweep and the user.
    // In a RUN cycle that also samples clear, the user write still lands; the
    // sweep that follows overwrites it.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = waddr;
        mem_wd = wdata;
        if (!run) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt;
            mem_wd = '0;
        end else if (we) begin
            mem_we = 1'b1;
        end
    end

    // The array carries no reset; the INIT sweep is what initialises it.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Stage p0: read address decode and read-during-write bypass
    assign rd_en_p0   = run & re;
    assign rdw_hit_p0 = (WRITE_FIRST != 0) && we && (waddr == raddr);
    assign rd_word_p0 = rdw_hit_p0 ? wdata : mem[raddr];

    // Stage p1: registered read data and its valid strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= rd_en_p0;
            if (rd_en_p0) begin
                rdata_p1 <= rd_word_p0;
            end
        end
    end

    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;

endmodule

// File: tb/tb_ram_sync_dp.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_ram_sync_dp
//   Self-checking bench for ram_sync_dp. Two instances share every input: one
//   built write-first, one read-first, so both read-during-write policies are
//   exercised by the same stimulus. A behavioural model predicts each read and
//   pushes the expected words to per-instance queues; they are popped when the
//   model says rvalid should be high.
// -----------------------------------------------------------------------------
module tb_ram_sync_dp;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              we    = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              re    = 1'b0;
    logic [ADDR_W-1:0] raddr = '0;

    logic [DATA_W-1:0] rdata_wf, rdata_rf;
    logic              rvalid_wf, rvalid_rf;
    logic              busy_wf, busy_rf;

    always #1 clock = ~clock;

    ram_sync_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_FIRST(1)) u_wf (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata_wf),
        .rvalid (rvalid_wf),
        .busy   (busy_wf)
    );

    ram_sync_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_FIRST(0)) u_rf (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata_rf),
        .rvalid (rvalid_rf),
        .busy   (busy_rf)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_busy = 1'b1;
    int                m_cnt  = 0;
    logic              m_vld  = 1'b0;
    logic [DATA_W-1:0] hold_wf = '0;
    logic [DATA_W-1:0] hold_rf = '0;
    logic [DATA_W-1:0] q_wf [$];
    logic [DATA_W-1:0] q_rf [$];

    // Model reaction to reset assertion.
    task automatic start_reset();
        reset   = 1'b1;
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_vld   = 1'b0;
        hold_wf = '0;
        hold_rf = '0;
        q_wf.delete();
        q_rf.delete();
    endtask

    // Advance the model by one edge using the inputs as they stand, then let
    // the DUT take the same edge; returns on the following falling edge.
    task automatic tick();
        if (!reset) begin
            if (m_busy) begin
                m_mem[m_cnt] = '0;
                m_vld = 1'b0;
                if (m_cnt == DEPTH - 1) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_vld = re;
                if (re) begin
                    q_rf.push_back(m_mem[raddr]);
                    q_wf.push_back((we && waddr == raddr) ? wdata : m_mem[raddr]);
                end
                if (we) m_mem[waddr] = wdata;
                if (clear) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        int nb;
        start_reset();
        #0.4;
        n_vec++;
        if (busy_wf !== 1'b1 || busy_rf !== 1'b1) begin
            n_bad++; $display("FAIL reset_busy: got %b/%b want 1", busy_wf, busy_rf);
        end
        n_vec++;
        if (rvalid_wf !== 1'b0 || rvalid_rf !== 1'b0) begin
            n_bad++; $display("FAIL reset_rvalid: got %b/%b want 0", rvalid_wf, rvalid_rf);
        end
        n_vec++;
        if (rdata_wf !== 8'h00 || rdata_rf !== 8'h00) begin
            n_bad++; $display("FAIL reset_rdata: got %h/%h want 00", rdata_wf, rdata_rf);
        end
        @(negedge clock);
        repeat (2) tick();
        reset = 1'b0;
        nb = (busy_wf === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if (busy_wf !== m_busy || busy_rf !== m_busy) begin
                n_bad++; $display("FAIL reset_init_busy: got %b/%b want %b", busy_wf, busy_rf, m_busy);
            end
            if (busy_wf !== 1'b1) break;
            nb++;
        end
        n_vec++;
        if (nb != 32) begin
            n_bad++; $display("FAIL reset_init_len: got %0d cycles want 32", nb);
        end
        for (int j = 0; j < DEPTH; j++) begin
            re = 1'b1; raddr = j[ADDR_W-1:0];
            tick();
            n_vec++;
            if (rvalid_wf !== m_vld || rvalid_rf !== m_vld) begin
                n_bad++; $display("FAIL reset_read_vld[%0d]: got %b/%b want %b", j, rvalid_wf, rvalid_rf, m_vld);
            end
            if (m_vld && q_wf.size() > 0) begin hold_wf = q_wf.pop_front(); hold_rf = q_rf.pop_front(); end
            n_vec++;
            if (rdata_wf !== hold_wf || rdata_rf !== hold_rf || rdata_wf !== 8'h00) begin
                n_bad++; $display("FAIL reset_read_data[%0d]: got %h/%h want %h/%h", j, rdata_wf, rdata_rf, hold_wf, hold_rf);
            end
        end
        re = 1'b0;
    endtask

    task automatic test_write_read();
        for (int j = 0; j < DEPTH; j++) begin
            we = 1'b1; waddr = j[ADDR_W-1:0]; wdata = 8'(j + 1);
            tick();
            n_vec++;
            if (rvalid_wf !== 1'b0 || rvalid_rf !== 1'b0) begin
                n_bad++; $display("FAIL wr_rvalid[%0d]: got %b/%b want 0", j, rvalid_wf, rvalid_rf);
            end
        end
        we = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            re = 1'b1; raddr = j[ADDR_W-1:0];
            tick();
            n_vec++;
            if (rvalid_wf !== m_vld || rvalid_rf !== m_vld || rvalid_wf !== 1'b1) begin
                n_bad++; $display("FAIL rd_vld[%0d]: got %b/%b want %b", j, rvalid_wf, rvalid_rf, m_vld);
            end
            if (m_vld && q_wf.size() > 0) begin hold_wf = q_wf.pop_front(); hold_rf = q_rf.pop_front(); end
            n_vec++;
            if (rdata_wf !== hold_wf || rdata_rf !== hold_rf || rdata_wf !== 8'(j + 1)) begin
                n_bad++; $display("FAIL rd_data[%0d]: got %h/%h want %h/%h", j, rdata_wf, rdata_rf, hold_wf, hold_rf);
            end
        end
        re = 1'b0;
        tick();
        n_vec++;
        if (rvalid_wf !== 1'b0 || rvalid_rf !== 1'b0) begin
            n_bad++; $display("FAIL rd_idle_vld: got %b/%b want 0", rvalid_wf, rvalid_rf);
        end
        n_vec++;
        if (rdata_wf !== 8'h20 || rdata_rf !== 8'h20) begin
            n_bad++; $display("FAIL rd_idle_hold: got %h/%h want 20", rdata_wf, rdata_rf);
        end
    endtask

    task automatic test_read_during_write();
        // same-address collision, then a re-read, then independent addresses
        logic [DATA_W-1:0] want_wf [4];
        logic [DATA_W-1:0] want_rf [4];
        want_wf[0] = 8'hAA; want_rf[0] = 8'h06;
        want_wf[1] = 8'hAA; want_rf[1] = 8'hAA;
        want_wf[2] = 8'h0A; want_rf[2] = 8'h0A;
        want_wf[3] = 8'h77; want_rf[3] = 8'h77;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin we = 1'b1; waddr = 5'd5; wdata = 8'hAA; re = 1'b1; raddr = 5'd5; end
                1: begin we = 1'b0; re = 1'b1; raddr = 5'd5; end
                2: begin we = 1'b1; waddr = 5'd7; wdata = 8'h77; re = 1'b1; raddr = 5'd9; end
                default: begin we = 1'b0; re = 1'b1; raddr = 5'd7; end
            endcase
            tick();
            n_vec++;
            if (rvalid_wf !== m_vld || rvalid_rf !== m_vld) begin
                n_bad++; $display("FAIL rdw_vld[%0d]: got %b/%b want %b", k, rvalid_wf, rvalid_rf, m_vld);
            end
            if (m_vld && q_wf.size() > 0) begin hold_wf = q_wf.pop_front(); hold_rf = q_rf.pop_front(); end
            n_vec++;
            if (rdata_wf !== hold_wf || rdata_rf !== hold_rf) begin
                n_bad++; $display("FAIL rdw_model[%0d]: got %h/%h want %h/%h", k, rdata_wf, rdata_rf, hold_wf, hold_rf);
            end
            n_vec++;
            if (rdata_wf !== want_wf[k] || rdata_rf !== want_rf[k]) begin
                n_bad++; $display("FAIL rdw_const[%0d]: got %h/%h want %h/%h", k, rdata_wf, rdata_rf, want_wf[k], want_rf[k]);
            end
        end
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_clear();
        int nb;
        // clear together with a write and a read: both still happen
        clear = 1'b1; we = 1'b1; waddr = 5'd0; wdata = 8'hEE; re = 1'b1; raddr = 5'd2;
        tick();
        clear = 1'b0; we = 1'b0; re = 1'b0;
        n_vec++;
        if (rvalid_wf !== 1'b1 || rvalid_rf !== 1'b1) begin
            n_bad++; $display("FAIL clr_same_cycle_vld: got %b/%b want 1", rvalid_wf, rvalid_rf);
        end
        if (m_vld && q_wf.size() > 0) begin hold_wf = q_wf.pop_front(); hold_rf = q_rf.pop_front(); end
        n_vec++;
        if (rdata_wf !== hold_wf || rdata_rf !== hold_rf || rdata_wf !== 8'h03) begin
            n_bad++; $display("FAIL clr_same_cycle_data: got %h/%h want 03", rdata_wf, rdata_rf);
        end
        nb = (busy_wf === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            clear = (i == 9);
            tick();
            n_vec++;
            if (busy_wf !== m_busy || busy_rf !== m_busy || rvalid_wf !== 1'b0 || rdata_wf !== 8'h03) begin
                n_bad++; $display("FAIL clr_init: got busy %b/%b vld %b data %h want busy %b vld 0 data 03",
                                  busy_wf, busy_rf, rvalid_wf, rdata_wf, m_busy);
            end
            if (busy_wf !== 1'b1) break;
            nb++;
        end
        clear = 1'b0;
        n_vec++;
        if (nb != 32) begin
            n_bad++; $display("FAIL clr_len: got %0d cycles want 32", nb);
        end
        for (int j = 0; j < DEPTH; j++) begin
            re = 1'b1; raddr = j[ADDR_W-1:0];
            tick();
            if (m_vld && q_wf.size() > 0) begin hold_wf = q_wf.pop_front(); hold_rf = q_rf.pop_front(); end
            n_vec++;
            if (rvalid_wf !== 1'b1 || rdata_wf !== hold_wf || rdata_rf !== hold_rf || rdata_wf !== 8'h00) begin
                n_bad++; $display("FAIL clr_read[%0d]: got vld %b data %h/%h want vld 1 data 00", j, rvalid_wf, rdata_wf, rdata_rf);
            end
        end
        re = 1'b0;
    endtask

    task automatic test_init_ignore();
        int guard;
        we = 1'b1; waddr = 5'd3; wdata = 8'h33;
        tick();
        we = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        guard = 0;
        while (m_busy && guard < 40) begin
            we = 1'b1; waddr = 5'd3; wdata = 8'h55; re = 1'b1; raddr = 5'd3;
            tick();
            guard++;
            n_vec++;
            if (rvalid_wf !== 1'b0 || rvalid_rf !== 1'b0 || rdata_wf !== hold_wf || rdata_rf !== hold_rf) begin
                n_bad++; $display("FAIL init_ignore[%0d]: got vld %b/%b data %h/%h want vld 0 data %h/%h",
                                  guard, rvalid_wf, rvalid_rf, rdata_wf, rdata_rf, hold_wf, hold_rf);
            end
        end
        we = 1'b0; re = 1'b1; raddr = 5'd3;
        tick();
        re = 1'b0;
        if (m_vld && q_wf.size() > 0) begin hold_wf = q_wf.pop_front(); hold_rf = q_rf.pop_front(); end
        n_vec++;
        if (rvalid_wf !== 1'b1 || rdata_wf !== 8'h00 || rdata_rf !== 8'h00) begin
            n_bad++; $display("FAIL init_ignore_read: got vld %b data %h/%h want vld 1 data 00", rvalid_wf, rdata_wf, rdata_rf);
        end
    endtask

    task automatic test_reset_mid_init();
        int nb;
        we = 1'b1; waddr = 5'd1; wdata = 8'h5A;
        tick();
        we = 1'b0; re = 1'b1; raddr = 5'd1;
        tick();
        re = 1'b0;
        if (m_vld && q_wf.size() > 0) begin hold_wf = q_wf.pop_front(); hold_rf = q_rf.pop_front(); end
        n_vec++;
        if (rdata_wf !== 8'h5A || rdata_rf !== 8'h5A) begin
            n_bad++; $display("FAIL rstmid_pre: got %h/%h want 5a", rdata_wf, rdata_rf);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        start_reset();
        #0.2;
        n_vec++;
        if (rdata_wf !== 8'h00 || rdata_rf !== 8'h00 || rvalid_wf !== 1'b0 || busy_wf !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_async: got data %h/%h vld %b busy %b want data 00 vld 0 busy 1",
                              rdata_wf, rdata_rf, rvalid_wf, busy_wf);
        end
        @(negedge clock);
        repeat (2) tick();
        reset = 1'b0;
        nb = (busy_wf === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if (busy_wf !== m_busy || busy_rf !== m_busy) begin
                n_bad++; $display("FAIL rstmid_busy: got %b/%b want %b", busy_wf, busy_rf, m_busy);
            end
            if (busy_wf !== 1'b1) break;
            nb++;
        end
        n_vec++;
        if (nb != 32) begin
            n_bad++; $display("FAIL rstmid_len: got %0d cycles want 32", nb);
        end
        re = 1'b1; raddr = 5'd1;
        tick();
        re = 1'b0;
        if (m_vld && q_wf.size() > 0) begin hold_wf = q_wf.pop_front(); hold_rf = q_rf.pop_front(); end
        n_vec++;
        if (rvalid_wf !== 1'b1 || rdata_wf !== 8'h00 || rdata_rf !== hold_rf) begin
            n_bad++; $display("FAIL rstmid_read: got vld %b data %h/%h want vld 1 data 00", rvalid_wf, rdata_wf, rdata_rf);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_during_write();
        test_clear();
        test_init_ignore();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
